// File: rtl/sys_ctrl_regs.sv
// -----------------------------------------------------------------------------
// sys_ctrl_regs
//
// System-control I/O register block sitting between Memory_Ctrl's I/O port and
// the UART, the video controller and the background-colour logic.  It provides
// buffered TX/RX UART FIFOs, readable control registers, sticky error flags and
// a free-running cycle counter, all word-addressed inside a 4 KiB I/O window.
//
// Register map (byte address, bits [1:0] ignored):
//   0x000 UART_TX/STATUS  W: push wdata[7:0] to TX FIFO
//                         R: {8'b0, tx_count, rx_count, 3'b0, tx_overflow,
//                             rx_overrun, tx_idle, rx_nonempty, tx_full}
//   0x004 BG_COLOR        R/W [23:0]
//   0x008 UART_DATA       R: {23'b0, rx_nonempty, rx_head}; read strobe pops
//   0x00C VIDEO_CTRL      R/W bit0 = framebuffer enable
//   0x010 FLAGS           W1C bit3 rx_overrun, bit4 tx_overflow; R: as STATUS
//   0x014 CYCLES          R: free-running 32-bit cycle counter
//   others                R: 0, writes ignored
//
// Ports:
//   clk_sys           system clock
//   reset_n           synchronous active-low reset
//   io_read_valid_i   one-cycle read strobe (pops UART_DATA at end of cycle)
//   io_write_valid_i  one-cycle write strobe
//   io_addr_i         byte address within the I/O window
//   io_wdata_i        write data
//   io_rdata_o        read data, registered every cycle from io_addr_i
//   uart_tx_data_o    byte presented to the UART transmitter
//   uart_tx_strobe_o  one-cycle TX valid
//   uart_tx_busy_i    UART transmitter busy
//   uart_rx_data_i    received byte
//   uart_rx_valid_i   received byte valid
//   uart_rx_ready_o   always ready; overflow is reported through rx_overrun
//   bg_col_o          background colour
//   video_fb_en_o     framebuffer enable
//   trace_o           last byte accepted into the TX FIFO (LED debug)
// -----------------------------------------------------------------------------
module sys_ctrl_regs #(
  parameter int          TX_DEPTH = 16,
  parameter int          RX_DEPTH = 16,
  parameter logic [23:0] BG_RESET = 24'h000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        io_read_valid_i,
  input  logic        io_write_valid_i,
  input  logic [11:0] io_addr_i,
  input  logic [31:0] io_wdata_i,
  output logic [31:0] io_rdata_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_strobe_o,
  input  logic        uart_tx_busy_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_valid_i,
  output logic        uart_rx_ready_o,
  output logic [23:0] bg_col_o,
  output logic        video_fb_en_o,
  output logic [7:0]  trace_o
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  // Word addresses (io_addr_i[11:2])
  localparam logic [9:0] A_STATUS = 10'h000;
  localparam logic [9:0] A_BG     = 10'h001;
  localparam logic [9:0] A_DATA   = 10'h002;
  localparam logic [9:0] A_VIDEO  = 10'h003;
  localparam logic [9:0] A_FLAGS  = 10'h004;
  localparam logic [9:0] A_CYCLES = 10'h005;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_HOLD = 2'd2
  } tx_state_t;

  logic [9:0]  word;
  logic        unused_bits;

  assign word            = io_addr_i[11:2];
  assign uart_rx_ready_o = 1'b1;
  // Byte-lane bits and the top write byte carry no meaning in this block.
  assign unused_bits     = ^{io_addr_i[1:0], io_wdata_i[31:24]};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wr;
  logic [TX_AW:0] tx_rd;
  logic [TX_AW:0] tx_count;
  logic           tx_empty;
  logic           tx_full;
  logic           tx_push_req;
  logic           tx_push;
  logic           tx_pop;
  logic           tx_drop;
  logic [7:0]     tx_head;
  tx_state_t      tx_state;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign tx_empty    = (tx_wr == tx_rd);
  assign tx_full     = (tx_wr[TX_AW] != tx_rd[TX_AW]) &&
                       (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]);
  assign tx_count    = tx_wr - tx_rd;
  assign tx_head     = tx_mem[tx_rd[TX_AW-1:0]];
  assign tx_push_req = io_write_valid_i && (word == A_STATUS);
  // SEND is only entered with data queued, so this pop never underflows.
  assign tx_pop      = (tx_state == TX_SEND);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop     = tx_push_req && tx_full && !tx_pop;

  always_ff @(posedge clk_sys) begin
    if (tx_push) begin
      tx_mem[tx_wr[TX_AW-1:0]] <= io_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tx_wr   <= '0;
      tx_rd   <= '0;
      trace_o <= '0;
    end else begin
      if (tx_push) begin
        tx_wr   <= tx_wr + 1'b1;
        trace_o <= io_wdata_i[7:0];
      end
      if (tx_pop) begin
        tx_rd <= tx_rd + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM: IDLE -> SEND (strobe, pop) -> HOLD -> IDLE.  HOLD gives the UART a
  // cycle to raise busy before the next head is considered, which also sets the
  // minimum strobe spacing to three cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tx_state         <= TX_IDLE;
      uart_tx_strobe_o <= 1'b0;
      uart_tx_data_o   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty && !uart_tx_busy_i) begin
            tx_state         <= TX_SEND;
            uart_tx_strobe_o <= 1'b1;
            uart_tx_data_o   <= tx_head;
          end
        end
        TX_SEND: begin
          tx_state         <= TX_HOLD;
          uart_tx_strobe_o <= 1'b0;
        end
        TX_HOLD: begin
          tx_state <= TX_IDLE;
        end
        default: begin
          tx_state         <= TX_IDLE;
          uart_tx_strobe_o <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wr;
  logic [RX_AW:0] rx_rd;
  logic [RX_AW:0] rx_count;
  logic           rx_empty;
  logic           rx_full;
  logic           rx_push;
  logic           rx_pop;
  logic           rx_drop;
  logic [7:0]     rx_head;

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[RX_AW] != rx_rd[RX_AW]) &&
                    (rx_wr[RX_AW-1:0] == rx_rd[RX_AW-1:0]);
  assign rx_count = rx_wr - rx_rd;
  assign rx_head  = rx_mem[rx_rd[RX_AW-1:0]];
  // Reading UART_DATA on an empty FIFO leaves the pointers alone.
  assign rx_pop   = io_read_valid_i && (word == A_DATA) && !rx_empty;
  assign rx_push  = uart_rx_valid_i && (!rx_full || rx_pop);
  assign rx_drop  = uart_rx_valid_i && rx_full && !rx_pop;

  always_ff @(posedge clk_sys) begin
    if (rx_push) begin
      rx_mem[rx_wr[RX_AW-1:0]] <= uart_rx_data_i;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push) begin
        rx_wr <= rx_wr + 1'b1;
      end
      if (rx_pop) begin
        rx_rd <= rx_rd + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags, control registers and cycle counter
  // ---------------------------------------------------------------------------
  logic        rx_overrun;
  logic        tx_overflow;
  logic        flags_wr;
  logic [31:0] cycles;

  assign flags_wr = io_write_valid_i && (word == A_FLAGS);

  // A new error event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      rx_overrun  <= (rx_overrun  && !(flags_wr && io_wdata_i[3])) || rx_drop;
      tx_overflow <= (tx_overflow && !(flags_wr && io_wdata_i[4])) || tx_drop;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bg_col_o      <= BG_RESET;
      video_fb_en_o <= 1'b0;
      cycles        <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (io_write_valid_i && (word == A_BG)) begin
        bg_col_o <= io_wdata_i[23:0];
      end
      if (io_write_valid_i && (word == A_VIDEO)) begin
        video_fb_en_o <= io_wdata_i[0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read decode, registered every cycle regardless of io_read_valid_i
  // ---------------------------------------------------------------------------
  logic        tx_idle;
  logic [31:0] status_word;
  logic [31:0] rdata_next;

  assign tx_idle     = tx_empty && (tx_state == TX_IDLE) && !uart_tx_busy_i;
  assign status_word = {8'b0, 8'(tx_count), 8'(rx_count), 3'b0,
                        tx_overflow, rx_overrun, tx_idle, !rx_empty, tx_full};

  always_comb begin
    rdata_next = '0;
    case (word)
      A_STATUS: rdata_next = status_word;
      A_BG:     rdata_next = {8'b0, bg_col_o};
      A_DATA:   rdata_next = {23'b0, !rx_empty, rx_head};
      A_VIDEO:  rdata_next = {31'b0, video_fb_en_o};
      A_FLAGS:  rdata_next = status_word;
      A_CYCLES: rdata_next = cycles;
      default:  rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      io_rdata_o <= '0;
    end else begin
      io_rdata_o <= rdata_next;
    end
  end

endmodule

// File: tb/tb_sys_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl_regs
//
// Self-checking bench for sys_ctrl_regs.  Control registers are exercised from
// a table of {write, read-back, expected} records; TX and RX traffic is checked
// against byte queues filled when stimulus is driven and drained when the DUT
// strobes a TX byte or returns an RX byte.
// -----------------------------------------------------------------------------
module tb_sys_ctrl_regs;

  localparam int          TX_DEPTH = 16;
  localparam int          RX_DEPTH = 16;
  localparam logic [23:0] BG_RESET = 24'h0A0B0C;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        io_read_valid;
  logic        io_write_valid;
  logic [11:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_strobe;
  logic        uart_tx_busy;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [23:0] bg_col;
  logic        video_fb_en;
  logic [7:0]  trace;

  sys_ctrl_regs #(
    .TX_DEPTH(TX_DEPTH),
    .RX_DEPTH(RX_DEPTH),
    .BG_RESET(BG_RESET)
  ) dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .io_read_valid_i (io_read_valid),
    .io_write_valid_i(io_write_valid),
    .io_addr_i       (io_addr),
    .io_wdata_i      (io_wdata),
    .io_rdata_o      (io_rdata),
    .uart_tx_data_o  (uart_tx_data),
    .uart_tx_strobe_o(uart_tx_strobe),
    .uart_tx_busy_i  (uart_tx_busy),
    .uart_rx_data_i  (uart_rx_data),
    .uart_rx_valid_i (uart_rx_valid),
    .uart_rx_ready_o (uart_rx_ready),
    .bg_col_o        (bg_col),
    .video_fb_en_o   (video_fb_en),
    .trace_o         (trace)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int last_strobe = -100;

  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];
  logic [7:0] mon_byte;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // TX scoreboard: every strobe must match the oldest queued byte.
  always @(negedge clk_sys) begin
    if (uart_tx_strobe) begin
      if (tx_exp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_unexpected: got strobe with 0x%02h, expected no strobe", uart_tx_data);
      end else begin
        mon_byte = tx_exp.pop_front();
        check("tx_data", {24'b0, uart_tx_data}, {24'b0, mon_byte});
      end
      check("tx_spacing_ge3", {31'b0, (cyc - last_strobe) >= 3}, 32'd1);
      last_strobe = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic write_reg(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk_sys);
    io_addr        = a;
    io_wdata       = d;
    io_write_valid = 1'b1;
    @(negedge clk_sys);
    io_write_valid = 1'b0;
  endtask

  // Address first, then the strobe cycle in which io_rdata is sampled.
  task automatic read_reg(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk_sys);
    io_addr = a;
    @(negedge clk_sys);
    io_read_valid = 1'b1;
    d = io_rdata;
    @(negedge clk_sys);
    io_read_valid = 1'b0;
  endtask

  task automatic rx_inject(input logic [7:0] b, input bit accepted);
    @(negedge clk_sys);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    if (accepted) rx_exp.push_back(b);
    @(negedge clk_sys);
    uart_rx_valid = 1'b0;
  endtask

  task automatic read_rx(input string name);
    logic [31:0] d;
    logic [7:0]  e;
    read_reg(12'h008, d);
    if (rx_exp.size() > 0) begin
      e = rx_exp.pop_front();
      check(name, d, {23'b0, 1'b1, e});
    end else begin
      check(name, d & 32'hFFFF_FF00, 32'h0);
    end
  endtask

  task automatic wait_tx_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (tx_exp.size() == 0) break;
      @(negedge clk_sys);
      #1;
    end
    #1;
    check("tx_drain_pending", tx_exp.size(), 32'd0);
  endtask

  typedef struct {
    logic        do_write;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp_rdata;
    logic [23:0] exp_bg;
    logic        exp_fb;
  } ctrl_vec_t;

  ctrl_vec_t   vec_tab [10];
  logic [31:0] d;
  logic [31:0] c0;
  logic [31:0] c1;
  logic [7:0]  burst [3];
  bit          seen;

  initial begin
    vec_tab[0] = '{1'b1, 12'h004, 32'h0012_3456, 12'h004, 32'h0012_3456, 24'h123456, 1'b0};
    vec_tab[1] = '{1'b1, 12'h004, 32'h0000_0000, 12'h004, 32'h0000_0000, 24'h000000, 1'b0};
    vec_tab[2] = '{1'b1, 12'h004, 32'hFFAB_CDEF, 12'h004, 32'h00AB_CDEF, 24'hABCDEF, 1'b0};
    vec_tab[3] = '{1'b1, 12'h00C, 32'h0000_0001, 12'h00C, 32'h0000_0001, 24'hABCDEF, 1'b1};
    vec_tab[4] = '{1'b1, 12'h00C, 32'hFFFF_FFFE, 12'h00C, 32'h0000_0000, 24'hABCDEF, 1'b0};
    vec_tab[5] = '{1'b1, 12'h00C, 32'h0000_0003, 12'h00C, 32'h0000_0001, 24'hABCDEF, 1'b1};
    vec_tab[6] = '{1'b1, 12'h020, 32'hDEAD_BEEF, 12'h020, 32'h0000_0000, 24'hABCDEF, 1'b1};
    vec_tab[7] = '{1'b0, 12'h000, 32'h0000_0000, 12'h7FC, 32'h0000_0000, 24'hABCDEF, 1'b1};
    vec_tab[8] = '{1'b1, 12'h016, 32'h0000_0055, 12'h006, 32'h00AB_CDEF, 24'hABCDEF, 1'b1};
    vec_tab[9] = '{1'b1, 12'h007, 32'h0000_0102, 12'h005, 32'h0000_0102, 24'h000102, 1'b1};
    burst[0] = 8'h41;
    burst[1] = 8'h42;
    burst[2] = 8'h43;

    reset_n        = 1'b0;
    io_read_valid  = 1'b0;
    io_write_valid = 1'b0;
    io_addr        = '0;
    io_wdata       = '0;
    uart_tx_busy   = 1'b0;
    uart_rx_data   = '0;
    uart_rx_valid  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_rdata", io_rdata, 32'h0);
    check("rst_tx_strobe", {31'b0, uart_tx_strobe}, 32'h0);
    check("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
    check("rst_bg_col", {8'b0, bg_col}, {8'b0, BG_RESET});
    check("rst_fb_en", {31'b0, video_fb_en}, 32'h0);
    check("rst_trace", {24'b0, trace}, 32'h0);
    check("rx_ready_tied", {31'b0, uart_rx_ready}, 32'h1);
    reset_n = 1'b1;

    // TX burst on back-to-back cycles
    @(negedge clk_sys);
    for (int i = 0; i < 3; i++) begin
      io_addr        = 12'h000;
      io_wdata       = {24'b0, burst[i]};
      io_write_valid = 1'b1;
      tx_exp.push_back(burst[i]);
      @(negedge clk_sys);
    end
    io_write_valid = 1'b0;
    check("trace_last_push", {24'b0, trace}, 32'h43);
    wait_tx_drain(60);
    repeat (3) @(negedge clk_sys);
    read_reg(12'h000, d);
    check("status_after_burst", d, 32'h0000_0004);

    // Control registers from the table
    for (int i = 0; i < 10; i++) begin
      if (vec_tab[i].do_write) write_reg(vec_tab[i].waddr, vec_tab[i].wdata);
      read_reg(vec_tab[i].raddr, d);
      check($sformatf("ctrl_rdata[%0d]", i), d, vec_tab[i].exp_rdata);
      check($sformatf("ctrl_bg[%0d]", i), {8'b0, bg_col}, {8'b0, vec_tab[i].exp_bg});
      check($sformatf("ctrl_fb[%0d]", i), {31'b0, video_fb_en}, {31'b0, vec_tab[i].exp_fb});
    end

    // RX basic
    rx_inject(8'h55, 1'b1);
    rx_inject(8'hAA, 1'b1);
    read_reg(12'h000, d);
    check("rx_status_two", d & 32'h0000_FF02, 32'h0000_0202);
    read_rx("rx_read_1");
    read_rx("rx_read_2");
    read_rx("rx_read_empty");
    read_reg(12'h000, d);
    check("rx_status_empty", d & 32'h0000_FF02, 32'h0);

    // RX fill, simultaneous push+pop when full, then overrun
    for (int i = 0; i < RX_DEPTH; i++) rx_inject(8'(8'h10 + i), 1'b1);
    read_reg(12'h000, d);
    check("rx_status_full", d & 32'h0000_FF0A, {16'b0, 8'(RX_DEPTH), 8'h02});
    @(negedge clk_sys);
    io_addr = 12'h008;
    @(negedge clk_sys);
    io_read_valid = 1'b1;
    uart_rx_data  = 8'hEE;
    uart_rx_valid = 1'b1;
    d = io_rdata;
    check("rx_simul_pop", d, {23'b0, 1'b1, rx_exp.pop_front()});
    rx_exp.push_back(8'hEE);
    @(negedge clk_sys);
    io_read_valid = 1'b0;
    uart_rx_valid = 1'b0;
    read_reg(12'h000, d);
    check("rx_simul_no_overrun", d & 32'h0000_FF0A, {16'b0, 8'(RX_DEPTH), 8'h02});
    rx_inject(8'h77, 1'b0);
    read_reg(12'h000, d);
    check("rx_overrun_set", d & 32'h0000_FF0A, {16'b0, 8'(RX_DEPTH), 8'h0A});
    // Overrun event and W1C in the same cycle: the set wins
    @(negedge clk_sys);
    io_addr        = 12'h010;
    io_wdata       = 32'h0000_0008;
    io_write_valid = 1'b1;
    uart_rx_data   = 8'h78;
    uart_rx_valid  = 1'b1;
    @(negedge clk_sys);
    io_write_valid = 1'b0;
    uart_rx_valid  = 1'b0;
    read_reg(12'h010, d);
    check("rx_overrun_set_wins", d & 32'h0000_0008, 32'h0000_0008);
    write_reg(12'h010, 32'h0000_0008);
    read_reg(12'h000, d);
    check("rx_overrun_cleared", d & 32'h0000_FF08, {16'b0, 8'(RX_DEPTH), 8'h00});
    for (int i = 0; i < RX_DEPTH; i++) read_rx($sformatf("rx_drain[%0d]", i));
    read_reg(12'h000, d);
    check("rx_drained", d & 32'h0000_FF0A, 32'h0);

    // TX overflow while the UART is busy
    uart_tx_busy = 1'b1;
    for (int i = 0; i < TX_DEPTH + 2; i++) begin
      write_reg(12'h000, 32'(8'h80 + i));
      if (i < TX_DEPTH) tx_exp.push_back(8'(8'h80 + i));
    end
    read_reg(12'h000, d);
    check("tx_overflow_status", d & 32'h00FF_0015, {8'b0, 8'(TX_DEPTH), 16'h0011});
    write_reg(12'h010, 32'h0000_0010);
    read_reg(12'h000, d);
    check("tx_overflow_cleared", d & 32'h00FF_0015, {8'b0, 8'(TX_DEPTH), 16'h0001});
    uart_tx_busy = 1'b0;
    wait_tx_drain(TX_DEPTH * 3 + 20);
    repeat (3) @(negedge clk_sys);
    read_reg(12'h000, d);
    check("status_after_overflow_drain", d, 32'h0000_0004);

    // Reset during SEND with three bytes queued
    uart_tx_busy = 1'b1;
    write_reg(12'h000, 32'h61);
    write_reg(12'h000, 32'h62);
    write_reg(12'h000, 32'h63);
    tx_exp.push_back(8'h61);
    @(negedge clk_sys);
    uart_tx_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (uart_tx_strobe) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_send_seen", {31'b0, seen}, 32'h1);
    #1 reset_n = 1'b0;
    @(negedge clk_sys);
    check("rst_mid_strobe", {31'b0, uart_tx_strobe}, 32'h0);
    check("rst_mid_rdata", io_rdata, 32'h0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    read_reg(12'h014, c0);
    check("cycles_restart", c0, 32'd1);
    read_reg(12'h014, c1);
    check("cycles_increment", c1 - c0, 32'd3);
    repeat (20) @(negedge clk_sys);
    read_reg(12'h000, d);
    check("rst_mid_status", d, 32'h0000_0004);
    check("rst_mid_bg", {8'b0, bg_col}, {8'b0, BG_RESET});
    check("rst_mid_fb", {31'b0, video_fb_en}, 32'h0);
    check("rst_mid_trace", {24'b0, trace}, 32'h0);
    check("tx_queue_empty_end", tx_exp.size(), 32'd0);
    check("rx_queue_empty_end", rx_exp.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_regs.md
Name: sys_ctrl_regs

Overview:
- Parametrised system-control I/O register block between Memory_Ctrl's I/O port and the UART, video controller and background-colour logic.
- Replaces the flat register decode with buffered TX/RX UART FIFOs, readable control registers, sticky error flags and a free-running cycle counter.
- All registers are word-addressed within a 4 KiB I/O window.

Parameters:
- TX_DEPTH, 16, TX FIFO entries (power of 2, >=2).
- RX_DEPTH, 16, RX FIFO entries (power of 2, >=2).
- BG_RESET, 24'h000000, reset value of the BG_COLOR register.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- io_read_valid_i  in  1  one-cycle read strobe from Memory_Ctrl
- io_write_valid_i  in  1  one-cycle write strobe
- io_addr_i  in  12  byte address within the I/O window (bits [1:0] ignored)
- io_wdata_i  in  32  write data
- io_rdata_o  out  32  registered read data
- uart_tx_data_o  out  8  byte to UART
- uart_tx_strobe_o  out  1  one-cycle TX valid
- uart_tx_busy_i  in  1  UART transmitter busy
- uart_rx_data_i  in  8  received byte
- uart_rx_valid_i  in  1  UART RX valid
- uart_rx_ready_o  out  1  RX accept; tied high
- bg_col_o  out  24  background colour
- video_fb_en_o  out  1  framebuffer enable
- trace_o  out  8  last byte accepted into the TX FIFO (LED debug)

Behaviour:
- Reset values: io_rdata_o=0, uart_tx_strobe_o=0, uart_tx_data_o=0, bg_col_o=BG_RESET, video_fb_en_o=0, trace_o=0.
- Reset effects: both FIFOs emptied, sticky flags cleared, cycle counter=0, TX FSM=IDLE.
- Reset mid-transfer aborts without emitting a further strobe.
- Register map (addr[11:2]):
  - 0x000 UART_TX/STATUS
    - Write: push io_wdata_i[7:0] to the TX FIFO.
    - Read: bit0 tx_full, bit1 rx_nonempty, bit2 tx_idle (FIFO empty & FSM IDLE & !uart_tx_busy_i), bit3 rx_overrun, bit4 tx_overflow, [15:8] RX count, [23:16] TX count; other bits 0.
  - 0x004 BG_COLOR: R/W [23:0]; every write is accepted, including 0.
  - 0x008 UART_DATA
    - Read: {23'b0, rx_nonempty, rx_head[7:0]}.
    - A read strobe pops one entry if the FIFO is non-empty; popping an empty FIFO has no effect.
  - 0x00C VIDEO_CTRL: R/W, bit0 = fb_en.
  - 0x010 FLAGS: write-1-to-clear bit3/bit4 from wdata[3] and wdata[4]; reads same as STATUS.
  - 0x014 CYCLES: read-only 32-bit counter, +1 per clock, wraps 0xFFFFFFFF->0.
  - Unmapped addresses: reads return 0; writes are ignored.
- Read timing:
  - io_rdata_o is registered every cycle from the decode of io_addr_i, so data is valid 1 cycle after the address.
  - The master holds the address >=1 cycle before io_read_valid_i and samples io_rdata_o in the strobe cycle.
  - The RX pop takes effect at the end of the strobe cycle.
- TX FIFO:
  - A write when full and with no pop in the same cycle is dropped and sets tx_overflow.
  - Simultaneous push+pop when full: the push is accepted and count is unchanged.
  - trace_o updates only on an accepted push.
- TX FSM:
  - IDLE: if FIFO non-empty & !uart_tx_busy_i -> SEND.
  - SEND: uart_tx_strobe_o=1 and uart_tx_data_o=head for exactly 1 cycle; pop -> HOLD.
  - HOLD: 1 cycle, absorbs the UART busy latency -> IDLE.
  - Minimum spacing between strobes is 3 cycles.
- RX FIFO:
  - Pushes on uart_rx_valid_i.
  - When full with no pop in the same cycle, the byte is dropped and rx_overrun is set.
  - Push+pop in the same cycle when full: the push is accepted.
- Sticky flags: a set and a W1C in the same cycle -> set wins.
- FIFO pointers use log2(DEPTH)+1 bits; full/empty come from MSB compare; counts saturate correctly at DEPTH.

Test Plan:
- TX burst: write 0x41,0x42,0x43 to 0x000 on back-to-back cycles, uart_tx_busy_i=0 -> three strobes carrying 0x41,0x42,0x43 in order, >=3 cycles apart; trace_o=0x43; STATUS bit2=1 once drained.
- TX overflow: hold uart_tx_busy_i=1 and write TX_DEPTH+2 bytes -> STATUS bit0=1, bit4=1, [23:16]=TX_DEPTH; the extra 2 bytes never appear; write 0x10 to FLAGS -> bit4=0.
- RX: inject 0x55 then 0xAA -> STATUS bit1=1, [15:8]=2; read 0x008 -> 0x155, then 0x1AA; third read -> 0x000AA-style data with bit8=0 and FIFO still empty.
- RX overrun with simultaneous events: fill the RX FIFO, then issue a push and a pop in the same cycle -> count stays RX_DEPTH and bit3=0; next push alone -> bit3=1.
- Control regs: write BG_COLOR=0 after 0x123456 -> bg_col_o=0; write VIDEO_CTRL=1 -> video_fb_en_o=1 and readback=1; read unmapped 0x020 -> 0.
- Reset mid-TX: assert reset_n=0 during SEND with 3 bytes queued -> no further strobes, STATUS reads tx_idle=1 with counts 0, bg_col_o=BG_RESET, CYCLES restarts from 0.
